// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: master FSM state encodings and response codes.
package axi_lite_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;
    localparam logic [2:0] ST_RSP     = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a cmd/rsp handshake pair into
// one AXI write (AW+W+B) or read (AR+R) transaction at a time.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int AXI_ADDRESS_WIDTH = 4
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,

    output logic [AXI_ADDRESS_WIDTH-1:0]  M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [AXI_ADDRESS_WIDTH-1:0]  M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    logic [2:0]                   state;
    logic                         aw_done, w_done;
    logic                         awvalid_q, wvalid_q, arvalid_q;
    logic [AXI_ADDRESS_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0]    wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0]  wstrb_q;
    logic                         aw_hs, w_hs, ar_hs;

    assign aw_hs = awvalid_q && M_AXI_AWREADY;
    assign w_hs  = wvalid_q  && M_AXI_WREADY;
    assign ar_hs = arvalid_q && M_AXI_ARREADY;

    assign cmd_ready     = (state == ST_IDLE);
    assign M_AXI_BREADY  = (state == ST_WR_RESP);
    assign M_AXI_RREADY  = (state == ST_RD_DATA);

    // One address register feeds both channels; only one is ever valid.
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_ARVALID = arvalid_q;

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state     <= ST_IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    addr_q  <= cmd_addr;
                    wdata_q <= cmd_wdata;
                    wstrb_q <= cmd_wstrb;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (cmd_write) begin
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state     <= ST_WR_REQ;
                    end else begin
                        arvalid_q <= 1'b1;
                        state     <= ST_RD_REQ;
                    end
                end
                ST_WR_REQ: begin
                    // AW and W complete independently, possibly in the same cycle.
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs))
                        state <= ST_WR_RESP;
                end
                ST_WR_RESP: if (M_AXI_BVALID) begin
                    rsp_resp  <= M_AXI_BRESP;
                    rsp_write <= 1'b1;
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                    state     <= ST_RSP;
                end
                ST_RD_REQ: if (ar_hs) begin
                    arvalid_q <= 1'b0;
                    state     <= ST_RD_DATA;
                end
                ST_RD_DATA: if (M_AXI_RVALID) begin
                    rsp_resp  <= M_AXI_RRESP;
                    rsp_rdata <= M_AXI_RDATA;
                    rsp_write <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= ST_RSP;
                end
                ST_RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    arvalid_q <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: cycle-level slave model plus per-transaction expectations.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid, rsp_write;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp = '0, rresp = '0;
    logic [DW-1:0] rdata = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_lite_master #(.AXI_DATA_WIDTH(DW), .AXI_ADDRESS_WIDTH(AW)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one command end to end, starting and ending just after a falling edge.
    // The slave raises each READY/VALID after the given number of eligible cycles;
    // every cycle the master's outputs are compared against what the AXI rules imply.
    task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input int aw_dly, input int w_dly,
                           input int ar_dly, input int d_dly, input logic [1:0] resp,
                           input logic [DW-1:0] rd, input int hold);
        bit aw_ok = 0, w_ok = 0, ar_ok = 0, bus_ok = 0, done = 0;
        bit aw_hs, w_hs, ar_hs, d_hs;
        int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, d_cnt = 0, hold_cnt = 0, cyc = 0;
        logic [DW-1:0] exp_rdata;
        exp_rdata = wr ? '0 : rd;

        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 0; cmd_addr = AW'($urandom); cmd_wdata = $urandom; cmd_wstrb = SW'($urandom);

        while (!done) begin
            if (wr) begin
                chk("awvalid", awvalid, !aw_ok);
                if (!aw_ok) chk("awaddr", awaddr, a);
                chk("wvalid", wvalid, !w_ok);
                if (!w_ok) begin
                    chk("wdata", wdata, d);
                    chk("wstrb", wstrb, s);
                end
                chk("bready", bready, aw_ok && w_ok && !bus_ok);
                chk("arvalid_wr", arvalid, 0);
                chk("rready_wr", rready, 0);
            end else begin
                chk("arvalid", arvalid, !ar_ok);
                if (!ar_ok) chk("araddr", araddr, a);
                chk("rready", rready, ar_ok && !bus_ok);
                chk("awvalid_rd", awvalid, 0);
                chk("wvalid_rd", wvalid, 0);
                chk("bready_rd", bready, 0);
            end
            chk("rsp_valid", rsp_valid, bus_ok);
            chk("cmd_ready_busy", cmd_ready, 0);
            if (bus_ok) begin
                chk("rsp_write", rsp_write, wr);
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_resp", rsp_resp, resp);
                if (hold_cnt >= hold) begin
                    rsp_ready = 1;
                    done = 1;
                end
                hold_cnt++;
            end

            awready = wr && !aw_ok && aw_cnt >= aw_dly;
            if (wr && !aw_ok) aw_cnt++;
            wready = wr && !w_ok && w_cnt >= w_dly;
            if (wr && !w_ok) w_cnt++;
            arready = !wr && !ar_ok && ar_cnt >= ar_dly;
            if (!wr && !ar_ok) ar_cnt++;
            if (wr) begin
                bvalid = aw_ok && w_ok && !bus_ok && d_cnt >= d_dly;
                if (aw_ok && w_ok && !bus_ok) d_cnt++;
                rvalid = 0;
            end else begin
                rvalid = ar_ok && !bus_ok && d_cnt >= d_dly;
                if (ar_ok && !bus_ok) d_cnt++;
                bvalid = 0;
            end
            bresp = bvalid ? resp : 2'($urandom);
            rresp = rvalid ? resp : 2'($urandom);
            rdata = rvalid ? rd : $urandom;
            aw_hs = awready; w_hs = wready; ar_hs = arready; d_hs = bvalid || rvalid;

            @(negedge clk);
            aw_ok |= aw_hs; w_ok |= w_hs; ar_ok |= ar_hs; bus_ok |= d_hs;
            cyc++;
            if (cyc > 200) begin
                chk("timeout", 0, 1);
                done = 1;
            end
        end
        rsp_ready = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        chk("rsp_valid_released", rsp_valid, 0);
        chk("cmd_ready_released", cmd_ready, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_write", rsp_write, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_resp", rsp_resp, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wstrb", wstrb, 0);
        rstn = 1;
        @(negedge clk);

        // Directed: simultaneous AW/W, staggered W, delayed AR, held rsp, SLVERR
        run_txn(1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, RESP_OKAY, '0, 0);
        run_txn(1, 4'h2, 32'hA5A5_1234, 4'h3, 0, 3, 0, 1, RESP_OKAY, '0, 0);
        run_txn(0, 4'h8, '0, '0, 0, 0, 2, 0, RESP_OKAY, 32'h12345678, 0);
        run_txn(0, 4'hC, '0, '0, 0, 0, 0, 1, RESP_EXOKAY, 32'hCAFEF00D, 5);
        run_txn(1, 4'hF, 32'h0BAD_F00D, 4'h5, 2, 0, 0, 2, RESP_SLVERR, '0, 5);

        // Reset while the write is stuck waiting on AW/W readiness
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h6; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 0;
        chk("pre_rst_awvalid", awvalid, 1);
        @(negedge clk);
        rstn = 0; bvalid = 1; bresp = RESP_DECERR;
        @(negedge clk);
        chk("mid_rst_awvalid", awvalid, 0);
        chk("mid_rst_wvalid", wvalid, 0);
        chk("mid_rst_bready", bready, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        rstn = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_no_rsp", rsp_valid, 0);
            chk("mid_rst_no_bready", bready, 0);
        end
        bvalid = 0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), AW'($urandom), $urandom, SW'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 3), 2'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
